// File: rtl/vr_udp_tx_arbiter_if.sv
// Bundle between the VR protocol engines, the TX arbiter and the UDP TX block.
// The master modport is the environment (engines plus UDP TX); the slave modport is the arbiter.
interface vr_udp_tx_arbiter_if #(
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned META_W     = 96,
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned PADBYTES_W = $clog2(DATA_W / 8),
    parameter int unsigned IDX_W      = $clog2(NUM_SRC)
);
    // Engine side, source i on slice i
    logic [NUM_SRC-1:0]            srcs_meta_val;
    logic [NUM_SRC*META_W-1:0]     srcs_meta;
    logic [NUM_SRC-1:0]            srcs_meta_rdy;
    logic [NUM_SRC-1:0]            srcs_data_val;
    logic [NUM_SRC*DATA_W-1:0]     srcs_data;
    logic [NUM_SRC-1:0]            srcs_data_last;
    logic [NUM_SRC*PADBYTES_W-1:0] srcs_data_padbytes;
    logic [NUM_SRC-1:0]            srcs_data_rdy;

    // UDP TX side
    logic                  arb_to_udp_meta_val;
    logic [META_W-1:0]     arb_to_udp_meta;
    logic                  udp_to_arb_meta_rdy;
    logic                  arb_to_udp_data_val;
    logic [DATA_W-1:0]     arb_to_udp_data;
    logic                  arb_to_udp_data_last;
    logic [PADBYTES_W-1:0] arb_to_udp_data_padbytes;
    logic                  udp_to_arb_data_rdy;

    // Status
    logic             arb_busy;
    logic [IDX_W-1:0] arb_grant_idx;

    modport master (
        output srcs_meta_val, srcs_meta, srcs_data_val, srcs_data, srcs_data_last,
               srcs_data_padbytes, udp_to_arb_meta_rdy, udp_to_arb_data_rdy,
        input  srcs_meta_rdy, srcs_data_rdy, arb_to_udp_meta_val, arb_to_udp_meta,
               arb_to_udp_data_val, arb_to_udp_data, arb_to_udp_data_last,
               arb_to_udp_data_padbytes, arb_busy, arb_grant_idx
    );

    modport slave (
        input  srcs_meta_val, srcs_meta, srcs_data_val, srcs_data, srcs_data_last,
               srcs_data_padbytes, udp_to_arb_meta_rdy, udp_to_arb_data_rdy,
        output srcs_meta_rdy, srcs_data_rdy, arb_to_udp_meta_val, arb_to_udp_meta,
               arb_to_udp_data_val, arb_to_udp_data, arb_to_udp_data_last,
               arb_to_udp_data_padbytes, arb_busy, arb_grant_idx
    );
endinterface

// File: rtl/vr_udp_tx_arbiter.sv
// Round-robin arbiter sharing the UDP TX metadata/data path between VR protocol engines.
// A grant is held from metadata acceptance through the last data beat, so messages never interleave.
module vr_udp_tx_arbiter #(
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned META_W     = 96,
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned PADBYTES_W = $clog2(DATA_W / 8),
    parameter int unsigned IDX_W      = $clog2(NUM_SRC)
) (
    input logic                clk,
    input logic                rst,
    vr_udp_tx_arbiter_if.slave bus
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_SRC - 1);
    localparam logic [IDX_W:0]   NumSrcW = (IDX_W + 1)'(NUM_SRC);

    typedef enum logic [1:0] {StIdle, StMeta, StData} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] prio_q, prio_d;

    logic [META_W-1:0]     meta_arr [NUM_SRC];
    logic [DATA_W-1:0]     data_arr [NUM_SRC];
    logic [PADBYTES_W-1:0] pad_arr  [NUM_SRC];

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W:0]   cand;
    logic             meta_val_sel;
    logic             data_val_sel;
    logic             meta_fire;
    logic             data_fire;

    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            meta_arr[i] = bus.srcs_meta[i*META_W +: META_W];
            data_arr[i] = bus.srcs_data[i*DATA_W +: DATA_W];
            pad_arr[i]  = bus.srcs_data_padbytes[i*PADBYTES_W +: PADBYTES_W];
        end
    end

    // First requester searching upward from prio_q, wrapping past the last source.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cand = {1'b0, prio_q} + (IDX_W + 1)'(i);
            if (cand >= NumSrcW) begin
                cand = cand - NumSrcW;
            end
            if (!pick_valid && bus.srcs_meta_val[cand[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign meta_val_sel = bus.srcs_meta_val[grant_q];
    assign data_val_sel = bus.srcs_data_val[grant_q];
    assign meta_fire    = (state_q == StMeta) && meta_val_sel && bus.udp_to_arb_meta_rdy;
    assign data_fire    = (state_q == StData) && data_val_sel && bus.udp_to_arb_data_rdy;

    // Payloads always come from the grantee; only the val signals are qualified by state.
    assign bus.arb_to_udp_meta          = meta_arr[grant_q];
    assign bus.arb_to_udp_data          = data_arr[grant_q];
    assign bus.arb_to_udp_data_last     = bus.srcs_data_last[grant_q];
    assign bus.arb_to_udp_data_padbytes = pad_arr[grant_q];
    assign bus.arb_busy                 = (state_q != StIdle);
    assign bus.arb_grant_idx            = grant_q;

    always_comb begin
        state_d                 = state_q;
        grant_d                 = grant_q;
        prio_d                  = prio_q;
        bus.srcs_meta_rdy       = '0;
        bus.srcs_data_rdy       = '0;
        bus.arb_to_udp_meta_val = 1'b0;
        bus.arb_to_udp_data_val = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = StMeta;
                end
            end
            StMeta: begin
                bus.arb_to_udp_meta_val    = meta_val_sel;
                bus.srcs_meta_rdy[grant_q] = bus.udp_to_arb_meta_rdy;
                if (meta_fire) begin
                    state_d = StData;
                end
            end
            StData: begin
                bus.arb_to_udp_data_val    = data_val_sel;
                bus.srcs_data_rdy[grant_q] = bus.udp_to_arb_data_rdy;
                if (data_fire && bus.srcs_data_last[grant_q]) begin
                    state_d = StIdle;
                    prio_d  = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            prio_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
        end
    end

endmodule

// File: tb/tb_vr_udp_tx_arbiter.sv
// Self-checking bench for vr_udp_tx_arbiter: engine models, UDP backpressure and an in-order
// scoreboard of expected metadata and data beats.
module tb_vr_udp_tx_arbiter;

    localparam int NUM_SRC = 3;
    localparam int META_W  = 96;
    localparam int DATA_W  = 256;
    localparam int PAD_W   = 5;
    localparam int IDX_W   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vr_udp_tx_arbiter_if #(
        .NUM_SRC   (NUM_SRC),
        .META_W    (META_W),
        .DATA_W    (DATA_W),
        .PADBYTES_W(PAD_W),
        .IDX_W     (IDX_W)
    ) bus ();

    vr_udp_tx_arbiter #(
        .NUM_SRC   (NUM_SRC),
        .META_W    (META_W),
        .DATA_W    (DATA_W),
        .PADBYTES_W(PAD_W),
        .IDX_W     (IDX_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [META_W-1:0] meta;
        int                src;
    } exp_meta_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [PAD_W-1:0]  pad;
    } exp_data_t;

    exp_meta_t exp_meta_q[$];
    exp_data_t exp_data_q[$];

    int checks   = 0;
    int failures = 0;

    // Engine model state
    bit active[NUM_SRC];
    bit phase[NUM_SRC];
    bit early[NUM_SRC];
    int beat[NUM_SRC];
    int nb[NUM_SRC];
    int cur_msg[NUM_SRC];
    int drv_msg[NUM_SRC];
    int pred_msg[NUM_SRC];
    int remaining[NUM_SRC];
    int cfg_beats[NUM_SRC];
    bit mf[NUM_SRC];
    bit df[NUM_SRC];

    // UDP side control
    int bp_meta_hold = 0;
    bit bp_toggle    = 1'b0;
    bit tog          = 1'b0;

    // Observations at the falling edge
    logic             obs_meta_val, obs_data_val, obs_busy;
    logic [IDX_W-1:0] obs_grant;
    logic [NUM_SRC-1:0] obs_meta_rdy, obs_data_rdy;
    bit prev_meta_stall, prev_data_stall;
    logic [META_W-1:0] prev_meta;
    logic [DATA_W-1:0] prev_data;
    logic              prev_last;
    int meta_stalls, data_stalls, early_holds;

    function automatic logic [META_W-1:0] make_meta(int s, int n);
        return {8'(s), 24'(n), 64'hFEED_0000_CAFE_0000 ^ {32'(n), 32'(s)}};
    endfunction

    function automatic logic [DATA_W-1:0] make_data(int s, int n, int b);
        logic [31:0] w;
        w = {8'(s), 8'(n), 8'(b), 8'hA5};
        return {8{w}} ^ DATA_W'(b * 1000 + n);
    endfunction

    function automatic logic [PAD_W-1:0] make_pad(int s, int n);
        return PAD_W'((s * 7 + n + 3) % 32);
    endfunction

    function automatic bit all_done();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (active[i] || remaining[i] > 0) return 1'b0;
        end
        return (exp_meta_q.size() == 0) && (exp_data_q.size() == 0);
    endfunction

    task automatic drive_sources();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!active[i] && remaining[i] > 0) begin
                active[i]  = 1'b1;
                phase[i]   = 1'b0;
                beat[i]    = 0;
                nb[i]      = cfg_beats[i];
                cur_msg[i] = drv_msg[i];
                drv_msg[i]++;
                remaining[i]--;
            end
            bus.srcs_meta_val[i] = active[i] && !phase[i];
            bus.srcs_meta[i*META_W +: META_W] = make_meta(i, cur_msg[i]);
            bus.srcs_data_val[i] = active[i] && (phase[i] || early[i]);
            bus.srcs_data[i*DATA_W +: DATA_W] = make_data(i, cur_msg[i], beat[i]);
            bus.srcs_data_last[i] = (beat[i] == nb[i] - 1);
            bus.srcs_data_padbytes[i*PAD_W +: PAD_W] =
                (beat[i] == nb[i] - 1) ? make_pad(i, cur_msg[i]) : '0;
        end
    endtask

    task automatic drive_udp();
        bus.udp_to_arb_meta_rdy = (bp_meta_hold == 0);
        if (bp_meta_hold > 0) bp_meta_hold--;
        tog = ~tog;
        bus.udp_to_arb_data_rdy = bp_toggle ? tog : 1'b1;
    endtask

    task automatic expect_msg(input int s, input int beats);
        exp_meta_t em;
        exp_data_t ed;
        em.meta = make_meta(s, pred_msg[s]);
        em.src  = s;
        exp_meta_q.push_back(em);
        for (int b = 0; b < beats; b++) begin
            ed.data = make_data(s, pred_msg[s], b);
            ed.last = (b == beats - 1);
            ed.pad  = ed.last ? make_pad(s, pred_msg[s]) : '0;
            exp_data_q.push_back(ed);
        end
        pred_msg[s]++;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NUM_SRC; i++) begin
            active[i]    = 1'b0;
            phase[i]     = 1'b0;
            early[i]     = 1'b0;
            beat[i]      = 0;
            remaining[i] = 0;
            pred_msg[i]  = drv_msg[i];
        end
        drive_sources();
    endtask

    // One clock: observe and score at the falling edge, advance the models after the rising edge.
    task automatic tick();
        exp_meta_t em;
        exp_data_t ed;
        bit        in_rst;
        @(negedge clk);
        in_rst       = rst;
        obs_meta_val = bus.arb_to_udp_meta_val;
        obs_data_val = bus.arb_to_udp_data_val;
        obs_busy     = bus.arb_busy;
        obs_grant    = bus.arb_grant_idx;
        obs_meta_rdy = bus.srcs_meta_rdy;
        obs_data_rdy = bus.srcs_data_rdy;
        for (int i = 0; i < NUM_SRC; i++) begin
            mf[i] = bus.srcs_meta_val[i] && bus.srcs_meta_rdy[i];
            df[i] = bus.srcs_data_val[i] && bus.srcs_data_rdy[i];
        end
        if (!in_rst) begin
            checks++;
            if ($countones(obs_meta_rdy) > 1) begin
                failures++;
                $display("FAIL meta_rdy_onehot got=%b required=at most one bit", obs_meta_rdy);
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (active[i] && phase[i]) begin
                    checks++;
                    if (obs_data_rdy[i] !== bus.udp_to_arb_data_rdy) begin
                        failures++;
                        $display("FAIL data_rdy_mirror src=%0d got=%b required=%b", i,
                                 obs_data_rdy[i], bus.udp_to_arb_data_rdy);
                    end
                end
                if (active[i] && !phase[i] && early[i]) begin
                    early_holds++;
                    checks++;
                    if (obs_data_rdy[i] !== 1'b0) begin
                        failures++;
                        $display("FAIL early_data_held src=%0d got=%b required=0", i,
                                 obs_data_rdy[i]);
                    end
                end
            end
            if (prev_meta_stall) begin
                checks++;
                if (obs_meta_val !== 1'b1 || bus.arb_to_udp_meta !== prev_meta) begin
                    failures++;
                    $display("FAIL meta_stall_stable got=%b/%h required=1/%h", obs_meta_val,
                             bus.arb_to_udp_meta, prev_meta);
                end
            end
            if (prev_data_stall) begin
                checks++;
                if (obs_data_val !== 1'b1 || bus.arb_to_udp_data !== prev_data ||
                    bus.arb_to_udp_data_last !== prev_last) begin
                    failures++;
                    $display("FAIL data_stall_stable got=%b/%h required=1/%h", obs_data_val,
                             bus.arb_to_udp_data, prev_data);
                end
            end
            if (obs_meta_val && bus.udp_to_arb_meta_rdy) begin
                checks++;
                if (exp_meta_q.size() == 0) begin
                    failures++;
                    $display("FAIL meta_unexpected got=%h required=no transfer", bus.arb_to_udp_meta);
                end else begin
                    em = exp_meta_q.pop_front();
                    if (bus.arb_to_udp_meta !== em.meta || obs_grant !== IDX_W'(em.src)) begin
                        failures++;
                        $display("FAIL meta_out got=%h grant=%0d required=%h grant=%0d",
                                 bus.arb_to_udp_meta, obs_grant, em.meta, em.src);
                    end
                end
            end
            if (obs_data_val && bus.udp_to_arb_data_rdy) begin
                checks++;
                if (exp_data_q.size() == 0) begin
                    failures++;
                    $display("FAIL data_unexpected got=%h required=no transfer", bus.arb_to_udp_data);
                end else begin
                    ed = exp_data_q.pop_front();
                    if (bus.arb_to_udp_data !== ed.data || bus.arb_to_udp_data_last !== ed.last ||
                        (ed.last && bus.arb_to_udp_data_padbytes !== ed.pad)) begin
                        failures++;
                        $display("FAIL data_out got=%h last=%b pad=%0d required=%h last=%b pad=%0d",
                                 bus.arb_to_udp_data, bus.arb_to_udp_data_last,
                                 bus.arb_to_udp_data_padbytes, ed.data, ed.last, ed.pad);
                    end
                end
            end
            prev_meta_stall = obs_meta_val && !bus.udp_to_arb_meta_rdy;
            prev_data_stall = obs_data_val && !bus.udp_to_arb_data_rdy;
            prev_meta       = bus.arb_to_udp_meta;
            prev_data       = bus.arb_to_udp_data;
            prev_last       = bus.arb_to_udp_data_last;
            if (prev_meta_stall) meta_stalls++;
            if (prev_data_stall) data_stalls++;
        end else begin
            prev_meta_stall = 1'b0;
            prev_data_stall = 1'b0;
        end
        @(posedge clk);
        #1;
        if (!in_rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (active[i] && mf[i]) phase[i] = 1'b1;
                if (active[i] && df[i]) begin
                    if (beat[i] == nb[i] - 1) active[i] = 1'b0;
                    else beat[i]++;
                end
            end
        end
        drive_sources();
        drive_udp();
    endtask

    task automatic run_until_done(input string name, input int max_cycles);
        int n;
        n = 0;
        while (!all_done() && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (!all_done()) begin
            failures++;
            $display("FAIL %s_drain got=meta:%0d data:%0d pending required=0 pending", name,
                     exp_meta_q.size(), exp_data_q.size());
        end
        tick();
        tick();
        checks++;
        if (obs_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_after got=%b required=0", name, obs_busy);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_sources();
        bp_meta_hold = 0;
        bp_toggle    = 1'b0;
        exp_meta_q.delete();
        exp_data_q.delete();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        cfg_beats[1] = 2;
        remaining[1] = 1;
        drive_sources();
        repeat (3) tick();
        checks += 6;
        if (obs_meta_val !== 1'b0) begin
            failures++; $display("FAIL reset_meta_val got=%b required=0", obs_meta_val);
        end
        if (obs_data_val !== 1'b0) begin
            failures++; $display("FAIL reset_data_val got=%b required=0", obs_data_val);
        end
        if (obs_meta_rdy !== '0) begin
            failures++; $display("FAIL reset_meta_rdy got=%b required=0", obs_meta_rdy);
        end
        if (obs_data_rdy !== '0) begin
            failures++; $display("FAIL reset_data_rdy got=%b required=0", obs_data_rdy);
        end
        if (obs_busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b required=0", obs_busy);
        end
        if (obs_grant !== '0) begin
            failures++; $display("FAIL reset_grant got=%0d required=0", obs_grant);
        end
        clear_sources();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (obs_busy !== 1'b0 || obs_meta_val !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle got=%b/%b required=0/0", obs_busy, obs_meta_val);
        end
    endtask

    task automatic test_single();
        do_reset();
        expect_msg(1, 3);
        cfg_beats[1] = 3;
        remaining[1] = 1;
        drive_sources();
        tick();
        checks++;
        if (obs_meta_val !== 1'b0 || obs_busy !== 1'b0) begin
            failures++;
            $display("FAIL single_arb_cycle got=%b/%b required=0/0", obs_meta_val, obs_busy);
        end
        tick();
        checks++;
        if (obs_meta_val !== 1'b1 || obs_grant !== 2'd1) begin
            failures++;
            $display("FAIL single_meta_latency got=%b grant=%0d required=1 grant=1",
                     obs_meta_val, obs_grant);
        end
        for (int b = 0; b < 3; b++) begin
            tick();
            checks++;
            if (obs_data_val !== 1'b1) begin
                failures++;
                $display("FAIL single_data_beat%0d got=%b required=1", b, obs_data_val);
            end
        end
        tick();
        checks++;
        if (obs_busy !== 1'b0 || obs_data_val !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_fall got=%b/%b required=0/0", obs_busy, obs_data_val);
        end
        // Priority now sits at source 2, so 2 must win over 0.
        expect_msg(2, 1);
        expect_msg(0, 1);
        cfg_beats[0] = 1; remaining[0] = 1;
        cfg_beats[2] = 1; remaining[2] = 1;
        drive_sources();
        run_until_done("single_prio", 40);
    endtask

    task automatic test_all_requesting();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < NUM_SRC; s++) expect_msg(s, 1);
        end
        for (int s = 0; s < NUM_SRC; s++) begin
            cfg_beats[s] = 1;
            remaining[s] = 2;
        end
        drive_sources();
        run_until_done("all_req", 100);
    endtask

    task automatic test_backpressure();
        do_reset();
        meta_stalls  = 0;
        data_stalls  = 0;
        expect_msg(1, 4);
        cfg_beats[1] = 4;
        remaining[1] = 1;
        bp_meta_hold = 4;
        bp_toggle    = 1'b1;
        tog          = 1'b0;
        bus.udp_to_arb_meta_rdy = 1'b0;
        drive_sources();
        run_until_done("backpressure", 100);
        checks += 2;
        if (meta_stalls != 4) begin
            failures++; $display("FAIL bp_meta_stalls got=%0d required=4", meta_stalls);
        end
        if (data_stalls != 4) begin
            failures++; $display("FAIL bp_data_stalls got=%0d required=4", data_stalls);
        end
        bp_toggle = 1'b0;
    endtask

    task automatic test_early_data();
        int n;
        do_reset();
        early_holds = 0;
        expect_msg(0, 4);
        expect_msg(2, 2);
        cfg_beats[0] = 4;
        remaining[0] = 1;
        drive_sources();
        n = 0;
        while (!(active[0] && phase[0] && beat[0] == 1) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!(active[0] && phase[0] && beat[0] == 1)) begin
            failures++;
            $display("FAIL early_wait_src0 got=beat %0d required=beat 1", beat[0]);
        end
        early[2]     = 1'b1;
        cfg_beats[2] = 2;
        remaining[2] = 1;
        drive_sources();
        run_until_done("early", 60);
        checks++;
        if (early_holds != 5) begin
            failures++; $display("FAIL early_hold_cycles got=%0d required=5", early_holds);
        end
        early[2] = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        expect_msg(0, 1);
        expect_msg(1, 4);
        cfg_beats[0] = 1; remaining[0] = 1;
        cfg_beats[1] = 4; remaining[1] = 1;
        drive_sources();
        n = 0;
        while (!(active[1] && phase[1] && beat[1] == 1) && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (!(active[1] && phase[1] && beat[1] == 1)) begin
            failures++;
            $display("FAIL rstmid_wait_src1 got=beat %0d required=beat 1", beat[1]);
        end
        rst = 1'b1;
        clear_sources();
        exp_meta_q.delete();
        exp_data_q.delete();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (obs_meta_val !== 1'b0 || obs_data_val !== 1'b0 || obs_meta_rdy !== '0 ||
            obs_data_rdy !== '0 || obs_busy !== 1'b0 || obs_grant !== '0) begin
            failures++;
            $display("FAIL rstmid_cleared got=%b%b %b %b busy=%b grant=%0d required=00 000 000 busy=0 grant=0",
                     obs_meta_val, obs_data_val, obs_meta_rdy, obs_data_rdy, obs_busy, obs_grant);
        end
        expect_msg(0, 1);
        expect_msg(1, 1);
        cfg_beats[0] = 1; remaining[0] = 1;
        cfg_beats[1] = 1; remaining[1] = 1;
        drive_sources();
        run_until_done("rstmid_rearb", 40);
    endtask

    task automatic test_wrap();
        do_reset();
        expect_msg(1, 1);
        cfg_beats[1] = 1; remaining[1] = 1;
        drive_sources();
        run_until_done("wrap_setup", 30);
        expect_msg(0, 1);
        cfg_beats[0] = 1; remaining[0] = 1;
        drive_sources();
        run_until_done("wrap_src0", 30);
        checks++;
        if (obs_grant !== 2'd0) begin
            failures++; $display("FAIL wrap_grant_hold got=%0d required=0", obs_grant);
        end
        // Priority is now 1: searching 1,2,0 must pick 2 before 0.
        expect_msg(2, 1);
        expect_msg(0, 1);
        cfg_beats[0] = 1; remaining[0] = 1;
        cfg_beats[2] = 1; remaining[2] = 1;
        drive_sources();
        run_until_done("wrap_prio", 40);
    endtask

    initial begin
        rst = 1'b1;
        bus.udp_to_arb_meta_rdy = 1'b1;
        bus.udp_to_arb_data_rdy = 1'b1;
        drive_sources();
        test_reset();
        test_single();
        test_all_requesting();
        test_backpressure();
        test_early_data();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
